aes_inv_key_sched: RTL
======================

// Module: aes_inv_key_sched
// PURPOSE
//  On-the-fly AES-128 inverse key schedule for the decrypt path. Loads the final
//  round key (round NR) and streams round keys NR, NR-1, ..., 0, one per accepted
//  valid/ready beat. Sits between the key register file and the inverse cipher
//  round datapath, so the decryptor does not need all 11 keys stored.
// PARAMETERS
//  NR     10  number of rounds; only 10 (AES-128) is supported, Rcon table is 10 entries
//  IDX_W  4   width of round_idx
// PORTS
//  clk         in   1      clock; all logic on rising edge
//  rst         in   1      synchronous active-high reset
//  start       in   1      request a new key stream; accepted only when busy=0
//  last_key    in   128    round-NR key; sampled on accepted start; word0 = [127:96]
//  key_ready   in   1      consumer accepts round_key this cycle
//  key_valid   out  1      round_key/round_idx valid
//  round_key   out  128    current round key, word0 = [127:96], byte0 of word = MSB
//  round_idx   out  IDX_W  round number of round_key (NR down to 0)
//  busy        out  1      stream in progress (STREAM state)
//  done        out  1      one-cycle pulse after round 0 is accepted
// BEHAVIOUR
//  - Reset: state=IDLE; key_valid=0, round_key=0, round_idx=0, busy=0, done=0.
//  - FSM IDLE -> STREAM on start&&!busy; STREAM -> IDLE on key_valid&&key_ready&&round_idx==0.
//  - Accepted start at edge N: from cycle N+1 key_valid=1, busy=1, round_key=last_key,
//    round_idx=NR. Latency start->first key = 1 cycle.
//  - Hold rule: while key_valid&&!key_ready, round_key/round_idx are stable.
//  - Beat (key_valid&&key_ready, round_idx=r>0): next cycle round_key = K(r-1),
//    round_idx=r-1, key_valid stays 1. Throughput one key per cycle.
//  - Inverse step, K(r)={a0,a1,a2,a3}, 32-bit words:
//    b3=a3^a2; b2=a2^a1; b1=a1^a0;
//    b0=a0 ^ SubWord(RotWord(b3)) ^ {Rcon[r-1],24'h0};
//    RotWord({x0,x1,x2,x3})={x1,x2,x3,x0}; SubWord = forward S-box per byte;
//    Rcon[0..9]=01,02,04,08,10,20,40,80,1b,36. Next-key logic is combinational on
//    the round_key register; one S-box bank of 4 instances.
//  - Final beat (r=0): next cycle key_valid=0, busy=0, round_key holds K(0),
//    round_idx=0, done=1 for exactly one cycle.
//  - start while busy=1: ignored, no effect on stream. start in the cycle done=1:
//    accepted (IDLE), new stream begins next cycle.
//  - key_ready while key_valid=0: ignored.
//  - rst mid-stream: returns to IDLE with reset values next cycle; no done pulse.
// CONFIGURATION
//  AES_KEY_FWD_EN  defined: adds input port dir (1 bit, sampled on accepted start).
//    dir=1 forward mode: last_key is taken as the cipher key K(0); stream is
//    K(0)..K(NR), round_idx counts 0 up to NR, step w4=w0^SubWord(RotWord(w3))^
//    Rcon[r], w5=w4^w1, w6=w5^w2, w7=w6^w3; done after round NR beat. Shares S-box bank.
//    dir=0: inverse behaviour above.
//  Not defined: no dir port; inverse-only behaviour; no forward logic synthesized.
// TESTING
//  1 Reset: assert rst 2 cycles -> all outputs 0, busy=0; start during rst ignored.
//  2 FIPS-197 A.1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start, key_ready=1 ->
//    idx10 d014f9a8..., idx9 ac7766f319fadc2128d12941575c006e, ...,
//    idx0 2b7e151628aed2a6abf7158809cf4f3c; done 1 cycle after idx0 beat; 11 beats total.
//  3 Backpressure: random key_ready (~50%) on vector 2 -> identical key sequence,
//    round_key/round_idx stable whenever key_valid&&!key_ready.
//  4 start pulsed at idx5 of a stream -> ignored, stream completes unchanged;
//    start in done cycle -> new stream, idx10 on next cycle.
//  5 rst asserted at idx6 -> IDLE next cycle, key_valid=0, no done; then a fresh run
//    of vector 2 passes.
//  6 AES_KEY_FWD_EN, dir=1, last_key=2b7e1516...4f3c -> idx0..idx10 ending
//    d014f9a8c9ee2589e13f0cc8b6630ca6; dir=0 rerun matches scenario 2.

Source files
------------

// File: rtl/aes_inv_key_sched.sv
// Streams AES-128 round keys on the fly from a single loaded key, one per valid/ready beat.
// Optional macro AES_KEY_FWD_EN adds a dir port so the same S-box bank can run the forward schedule too.
module aes_inv_key_sched #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef AES_KEY_FWD_EN
  input  logic             dir,
`endif
  input  logic [127:0]     last_key,
  input  logic             key_ready,
  output logic             key_valid,
  output logic [127:0]     round_key,
  output logic [IDX_W-1:0] round_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Forward S-box, byte 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
    case (int'(r))
      0:       return 8'h01;
      1:       return 8'h02;
      2:       return 8'h04;
      3:       return 8'h08;
      4:       return 8'h10;
      5:       return 8'h20;
      6:       return 8'h40;
      7:       return 8'h80;
      8:       return 8'h1b;
      9:       return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             r_state, w_state_next;
  logic [127:0]       r_key, w_key_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic               r_done, w_done_next;

  logic [31:0]        w_a0, w_a1, w_a2, w_a3;
  logic [31:0]        w_b1, w_b2, w_b3;
  logic [31:0]        w_sbox_in, w_sub, w_w0;
  logic [7:0]         w_rcon;
  logic [127:0]       w_step;
  logic               w_is_last;
  logic [IDX_W-1:0]   w_idx_step;
  logic [IDX_W-1:0]   w_first_idx;

  assign {w_a0, w_a1, w_a2, w_a3} = r_key;
  assign w_b3 = w_a3 ^ w_a2;
  assign w_b2 = w_a2 ^ w_a1;
  assign w_b1 = w_a1 ^ w_a0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign w_sub[gi*8 +: 8] = sbox(w_sbox_in[gi*8 +: 8]);
  end

  // Word 0 has the same form in both directions; only the S-box source and Rcon index differ.
  assign w_w0 = w_a0 ^ w_sub ^ {w_rcon, 24'h000000};

`ifdef AES_KEY_FWD_EN
  logic         r_dir;
  logic [31:0]  w_f1, w_f2, w_f3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_dir <= dir;
    end
  end

  assign w_sbox_in   = r_dir ? {w_a3[23:0], w_a3[31:24]} : {w_b3[23:0], w_b3[31:24]};
  assign w_rcon      = rcon(r_dir ? r_idx : r_idx - IDX_ONE);
  assign w_f1        = w_w0 ^ w_a1;
  assign w_f2        = w_f1 ^ w_a2;
  assign w_f3        = w_f2 ^ w_a3;
  assign w_step      = r_dir ? {w_w0, w_f1, w_f2, w_f3} : {w_w0, w_b1, w_b2, w_b3};
  assign w_is_last   = r_dir ? (r_idx == LAST_IDX) : (r_idx == '0);
  assign w_idx_step  = r_dir ? r_idx + IDX_ONE : r_idx - IDX_ONE;
  assign w_first_idx = dir ? '0 : LAST_IDX;
`else
  assign w_sbox_in   = {w_b3[23:0], w_b3[31:24]};
  assign w_rcon      = rcon(r_idx - IDX_ONE);
  assign w_step      = {w_w0, w_b1, w_b2, w_b3};
  assign w_is_last   = (r_idx == '0);
  assign w_idx_step  = r_idx - IDX_ONE;
  assign w_first_idx = LAST_IDX;
`endif

  always_comb begin
    w_state_next = r_state;
    w_key_next   = r_key;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_STREAM;
          w_key_next   = last_key;
          w_idx_next   = w_first_idx;
        end
      end
      S_STREAM: begin
        if (key_ready) begin
          // Final key stays on round_key after the stream closes.
          if (w_is_last) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_key_next = w_step;
            w_idx_next = w_idx_step;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_key   <= w_key_next;
      r_idx   <= w_idx_next;
      r_done  <= w_done_next;
    end
  end

  assign key_valid = (r_state == S_STREAM);
  assign busy      = (r_state == S_STREAM);
  assign round_key = r_key;
  assign round_idx = r_idx;
  assign done      = r_done;

endmodule
